// File: rtl/wind_stats_pkg.sv
// Shared constants and state encoding for the wind statistics block.
// Optional gust-angle tracking is enabled with WIND_STATS_GUSTANGLE_EN.
package wind_stats_pkg;

    localparam int DW_DEF    = 16;
    localparam int WLMAX_DEF = 10;
    localparam int CW_DEF    = 16;
    localparam int SW_DEF    = DW_DEF + WLMAX_DEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/wind_stats_extreme.sv
// Running max/min tracker for one statistics window; the *_incl outputs already
// include the sample presented this cycle. Gust angle needs WIND_STATS_GUSTANGLE_EN.
module wind_stats_extreme
    import wind_stats_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_init,
    input  logic          i_strobe,
    input  logic [DW-1:0] i_value,
    input  logic [15:0]   i_angle,
    output logic [DW-1:0] o_max_incl,
    output logic [DW-1:0] o_min_incl,
    output logic [15:0]   o_angle_incl
);

    logic [DW-1:0] r_max;
    logic [DW-1:0] r_min;
    logic          w_max_upd;
    logic          w_min_upd;

    // Strict compares so the first occurrence of a tie is kept.
    assign w_max_upd = i_strobe && (i_value > r_max);
    assign w_min_upd = i_strobe && (i_value < r_min);

    // Combinational view of the extremes including the current sample
    always_comb begin
        o_max_incl = r_max;
        o_min_incl = r_min;
        if (w_max_upd) begin
            o_max_incl = i_value;
        end else begin
            o_max_incl = r_max;
        end
        if (w_min_upd) begin
            o_min_incl = i_value;
        end else begin
            o_min_incl = r_min;
        end
    end

    // Extreme registers; init restarts the window and wins over a sample
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_max <= {DW{1'b0}};
            r_min <= {DW{1'b1}};
        end else if (i_init) begin
            r_max <= {DW{1'b0}};
            r_min <= {DW{1'b1}};
        end else begin
            if (w_max_upd) r_max <= i_value;
            if (w_min_upd) r_min <= i_value;
        end
    end

`ifdef WIND_STATS_GUSTANGLE_EN
    logic [15:0] r_angle;

    // Angle of the current maximum sample
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_angle <= 16'h0000;
        end else if (i_init) begin
            r_angle <= 16'h0000;
        end else if (w_max_upd) begin
            r_angle <= i_angle;
        end
    end

    assign o_angle_incl = w_max_upd ? i_angle : r_angle;
`else
    logic w_unused_angle;
    assign w_unused_angle = ^i_angle;
    assign o_angle_incl   = 16'h0000;
`endif

endmodule

// File: rtl/wind_stats.sv
// Windowed mean/gust/lull statistics over 2^winlen wind-speed samples.
// Define WIND_STATS_GUSTANGLE_EN to report the angle of the gust sample.
module wind_stats
    import wind_stats_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int WLMAX = WLMAX_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          clear,
    input  logic [3:0]    winlen,
    input  logic          newdata,
    input  logic [DW-1:0] mod,
    input  logic [15:0]   angle,
    output logic [DW-1:0] meanspd,
    output logic [DW-1:0] gust,
    output logic [DW-1:0] lull,
    output logic [15:0]   gustangle,
    output logic [CW-1:0] nwindows,
    output logic          statvalid
);

    localparam int SW   = DW + WLMAX;
    localparam int CNTW = WLMAX + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_sum;
    logic [CNTW-1:0] r_cnt;
    logic [3:0]      r_wl;

    logic [3:0]      w_wl_clamp;
    logic [CNTW-1:0] w_n_minus1;
    logic            w_acc_live;
    logic            w_sample;
    logic            w_complete;
    logic            w_init;
    logic            w_latch_wl;
    logic [SW-1:0]   w_sum_incl;
    logic [DW-1:0]   w_mean;
    logic [DW-1:0]   w_max_incl;
    logic [DW-1:0]   w_min_incl;
    logic [15:0]     w_angle_incl;

    assign w_wl_clamp = (winlen > 4'(WLMAX)) ? 4'(WLMAX) : winlen;
    assign w_n_minus1 = (CNTW'(1) << r_wl) - CNTW'(1);
    assign w_acc_live = (r_state == ST_ACC) && enable;
    assign w_sample   = w_acc_live && newdata && !clear;
    assign w_complete = w_sample && (r_cnt == w_n_minus1);
    // Accumulators restart while idle, on clear and at every window boundary.
    assign w_init     = !w_acc_live || clear || w_complete;
    assign w_latch_wl = ((r_state == ST_IDLE) && enable) || w_complete;
    assign w_sum_incl = r_sum + SW'(mod);
    assign w_mean     = DW'(w_sum_incl >> r_wl);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enable alone moves between IDLE and ACC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_ACC;
                else        w_state_nxt = ST_IDLE;
            end
            ST_ACC: begin
                if (!enable) w_state_nxt = ST_IDLE;
                else         w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sum, sample counter and latched window length
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= {SW{1'b0}};
            r_cnt <= {CNTW{1'b0}};
            r_wl  <= 4'd0;
        end else begin
            if (w_init) begin
                r_sum <= {SW{1'b0}};
                r_cnt <= {CNTW{1'b0}};
            end else if (w_sample) begin
                r_sum <= w_sum_incl;
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_latch_wl) r_wl <= w_wl_clamp;
        end
    end

    wind_stats_extreme #(
        .DW (DW)
    ) u_extreme (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_init       (w_init),
        .i_strobe     (w_sample),
        .i_value      (mod),
        .i_angle      (angle),
        .o_max_incl   (w_max_incl),
        .o_min_incl   (w_min_incl),
        .o_angle_incl (w_angle_incl)
    );

    // Result snapshots, window counter and the one-cycle valid pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meanspd   <= {DW{1'b0}};
            gust      <= {DW{1'b0}};
            lull      <= {DW{1'b0}};
            gustangle <= 16'h0000;
            nwindows  <= {CW{1'b0}};
            statvalid <= 1'b0;
        end else begin
            statvalid <= w_complete;
            if (w_complete) begin
                meanspd   <= w_mean;
                gust      <= w_max_incl;
                lull      <= w_min_incl;
                gustangle <= w_angle_incl;
            end
            if (clear) begin
                nwindows <= {CW{1'b0}};
            end else if (w_complete) begin
                nwindows <= nwindows + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wind_stats.sv
// Self-checking bench for wind_stats: directed scenarios plus randomized traffic
// compared against a sample-queue reference model.
module tb_wind_stats;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [3:0]  winlen;
    logic        newdata;
    logic [15:0] mod;
    logic [15:0] angle;
    logic [15:0] meanspd;
    logic [15:0] gust;
    logic [15:0] lull;
    logic [15:0] gustangle;
    logic [15:0] nwindows;
    logic        statvalid;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit          m_acc;
    int          m_wl;
    logic [15:0] q_mod[$];
    logic [15:0] q_ang[$];
    logic [15:0] e_mean, e_gust, e_lull, e_gang, e_nwin;
    logic        e_valid;

    wind_stats dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .winlen    (winlen),
        .newdata   (newdata),
        .mod       (mod),
        .angle     (angle),
        .meanspd   (meanspd),
        .gust      (gust),
        .lull      (lull),
        .gustangle (gustangle),
        .nwindows  (nwindows),
        .statvalid (statvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_wl(input int w);
        return (w > 10) ? 10 : w;
    endfunction

    task automatic model_reset();
        m_acc = 1'b0;
        m_wl  = 0;
        q_mod.delete();
        q_ang.delete();
        e_mean = 16'h0000; e_gust = 16'h0000; e_lull = 16'h0000;
        e_gang = 16'h0000; e_nwin = 16'h0000; e_valid = 1'b0;
    endtask

    task automatic finish_window(input int wl_next);
        longint s;
        int     imax, imin;
        s = 0; imax = 0; imin = 0;
        foreach (q_mod[i]) begin
            s += q_mod[i];
            if (q_mod[i] > q_mod[imax]) imax = i;
            if (q_mod[i] < q_mod[imin]) imin = i;
        end
        e_mean = 16'(s / (64'd1 << m_wl));
        e_gust = q_mod[imax];
        e_lull = q_mod[imin];
`ifdef WIND_STATS_GUSTANGLE_EN
        e_gang = q_ang[imax];
`else
        e_gang = 16'h0000;
`endif
        e_nwin  = e_nwin + 16'd1;
        e_valid = 1'b1;
        q_mod.delete();
        q_ang.delete();
        m_wl = clamp_wl(wl_next);
    endtask

    task automatic model_step(input logic en, input logic clr, input logic nd,
                              input logic [15:0] m, input logic [15:0] a, input int wl);
        e_valid = 1'b0;
        if (!m_acc) begin
            if (en) begin
                m_acc = 1'b1;
                m_wl  = clamp_wl(wl);
            end
            q_mod.delete(); q_ang.delete();
        end else if (!en) begin
            m_acc = 1'b0;
            q_mod.delete(); q_ang.delete();
        end else if (clr) begin
            q_mod.delete(); q_ang.delete();
        end else if (nd) begin
            q_mod.push_back(m);
            q_ang.push_back(a);
            if (q_mod.size() == (1 << m_wl)) finish_window(wl);
        end
        if (clr) e_nwin = 16'h0000;
    endtask

    task automatic check_all();
        chk("statvalid", 32'(statvalid), 32'(e_valid));
        chk("meanspd",   32'(meanspd),   32'(e_mean));
        chk("gust",      32'(gust),      32'(e_gust));
        chk("lull",      32'(lull),      32'(e_lull));
        chk("gustangle", 32'(gustangle), 32'(e_gang));
        chk("nwindows",  32'(nwindows),  32'(e_nwin));
    endtask

    task automatic step(input logic en, input logic clr, input logic nd,
                        input logic [15:0] m, input logic [15:0] a, input logic [3:0] wl);
        @(negedge clock);
        enable = en; clear = clr; newdata = nd; mod = m; angle = a; winlen = wl;
        model_step(en, clr, nd, m, a, int'(wl));
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] basic_mods [4];
        basic_mods[0] = 16'h0400; basic_mods[1] = 16'h0800;
        basic_mods[2] = 16'h0C00; basic_mods[3] = 16'h1000;

        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; winlen = 4'd0;
        newdata = 1'b0; mod = 16'h0000; angle = 16'h0000;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("reset_mean", 32'(meanspd), 32'h0);
        chk("reset_nwin", 32'(nwindows), 32'h0);
        chk("reset_valid", 32'(statvalid), 32'h0);
        reset_n = 1'b1;

        // basic window, newdata in the enabling cycle must be ignored
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0055, 4'd2);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, basic_mods[i], 16'(16'h1000 + i), 4'd2);
        chk("basic_mean", 32'(meanspd), 32'h0A00);
        chk("basic_gust", 32'(gust), 32'h1000);
        chk("basic_lull", 32'(lull), 32'h0400);
        chk("basic_nwin", 32'(nwindows), 32'h1);
        chk("basic_valid", 32'(statvalid), 32'h1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd2);
        chk("basic_valid_drop", 32'(statvalid), 32'h0);

        // single-sample windows
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0777, 4'd0);
            chk("wl0_mean", 32'(meanspd), 32'h1234);
            chk("wl0_lull", 32'(lull), 32'h1234);
        end

        // winlen 15 clamps to 1024 full-scale samples
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd15);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd15);
        for (int i = 0; i < 1024; i++)
            step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'($urandom), 4'd15);
        chk("clamp_mean", 32'(meanspd), 32'hFFFF);
        chk("clamp_valid", 32'(statvalid), 32'h1);

        // clear mid-window, clear wins over the simultaneous sample
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd2);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd2);
        step(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0001, 4'd2);
        step(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0002, 4'd2);
        step(1'b1, 1'b1, 1'b1, 16'h0F00, 16'h0003, 4'd2);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 16'h0200, 16'(i), 4'd2);
        chk("clear_mean", 32'(meanspd), 32'h0200);
        chk("clear_nwin", 32'(nwindows), 32'h1);

        // enable drop discards the partial window
        step(1'b1, 1'b0, 1'b1, 16'h0900, 16'h0000, 4'd2);
        step(1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0000, 4'd2);
        step(1'b0, 1'b0, 1'b1, 16'h0B00, 16'h0000, 4'd2);
        chk("drop_valid", 32'(statvalid), 32'h0);
        chk("drop_mean", 32'(meanspd), 32'h0200);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd2);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 16'(16'h0100 * (i + 1)), 16'(i), 4'd2);
        chk("reen_mean", 32'(meanspd), 32'h0280);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic       r_en, r_clr, r_nd;
            logic [3:0] r_wl;
            r_en  = ($urandom % 20) != 0;
            r_clr = ($urandom % 60) == 0;
            r_nd  = ($urandom % 2) == 0;
            r_wl  = (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'($urandom % 4);
            step(r_en, r_clr, r_nd, 16'($urandom), 16'($urandom), r_wl);
        end

        // asynchronous reset between clock edges
        step(1'b1, 1'b0, 1'b1, 16'h4321, 16'h0000, 4'd0);
        step(1'b1, 1'b0, 1'b1, 16'h1111, 16'h0000, 4'd1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_mean", 32'(meanspd), 32'h0);
        chk("arst_gust", 32'(gust), 32'h0);
        chk("arst_lull", 32'(lull), 32'h0);
        chk("arst_nwin", 32'(nwindows), 32'h0);
        chk("arst_gang", 32'(gustangle), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd1);
        step(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0AAA, 4'd1);
        step(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0BBB, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wind_stats.md
Name: wind_stats

Overview:
Downstream of the rectangular-to-polar stage; consumes each new wind speed/angle result and computes windowed statistics over 2^winlen samples.
- Statistics: mean speed, gust (max), lull (min), completed-window count.
- Results are exposed as registered snapshots for the ioports input ports, with a one-clock valid pulse per window.

Parameters:
DW, 16, width of speed sample and of the mean/max/min outputs (Q6.10 unsigned magnitude)
WLMAX, 10, maximum log2 window length; larger winlen values clamp to this
CW, 16, width of the completed-window counter

Ports:
clock  in  1  system clock (2 MHz domain)
reset_n  in  1  asynchronous reset, active low
enable  in  1  1 = accumulate; 0 = idle, discard partial window
clear  in  1  1-clock pulse: discard partial window, zero window counter
winlen  in  4  log2 window length, latched at window start
newdata  in  1  1-clock pulse; mod/angle valid this cycle
mod  in  DW  wind speed magnitude, unsigned
angle  in  16  wind angle, signed (used only with optional feature)
meanspd  out  DW  mean speed of last completed window
gust  out  DW  max speed of last window
lull  out  DW  min speed of last window
gustangle  out  16  angle at gust sample (optional feature)
nwindows  out  CW  completed windows since clear/reset, wraps
statvalid  out  1  1-clock pulse when outputs update

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, sum 0, count 0, internal max 0, internal min all-ones.
- Latched window length: wl = min(winlen, WLMAX), captured on IDLE->ACC and at each window completion. N = 2^wl.
- Accumulator: sum width DW+WLMAX (26 bits), so no overflow is possible. Sample counter is WLMAX+1 bits.
- IDLE:
  - enable=0 holds here; accumulators are re-initialised every cycle.
  - enable=1 -> ACC on the next edge; any newdata in that same cycle is ignored.
- ACC, newdata=1 and count < N-1:
  - sum += mod; count++.
  - max/min updated with strict compare: first occurrence wins ties.
- ACC, newdata=1 and count == N-1 (window complete):
  - Same edge: meanspd <= (sum+mod) >> wl (truncating); gust/lull <= max/min including this sample; nwindows++.
  - statvalid=1 for the following cycle only (registered).
  - Accumulators reinitialise; wl re-latched; remain in ACC.
  - Latency: outputs and statvalid visible 1 clock after the final sample edge.
- enable falls in ACC: -> IDLE; partial window discarded; outputs hold their last values.
- clear=1: partial window discarded and nwindows <= 0.
  - Clear beats a simultaneous newdata; that sample is lost.
  - Clear beats a simultaneous completion; no statvalid pulse.
  - Other outputs are held. State unchanged.
- winlen changes mid-window: no effect until the next window start.
- wl=0: every sample completes a window; mean=gust=lull=mod.
- newdata while IDLE: ignored.

Optional Feature:
WIND_STATS_GUSTANGLE_EN
- Defined: an internal 16-bit register captures angle whenever max updates. gustangle <= that angle at window completion.
- Not defined: gustangle tied to 0; the angle input is unused and no register is synthesised.

Decomposition:
- Package wind_stats_pkg: DW, WLMAX, CW defaults; sum width constant (DW+WLMAX); state encoding IDLE/ACC.
- One natural sub-module: wind_stats_extreme.
  - Tracks running max/min (plus gust angle when enabled).
  - Inputs: init, sample strobe, value, angle.
  - Instantiated once in wind_stats.

Test Plan:
- Basic window: winlen=2, enable=1, mods 0x0400,0x0800,0x0C00,0x1000 -> 1 clk after 4th: meanspd=0x0A00, gust=0x1000, lull=0x0400, nwindows=1, statvalid one cycle.
- wl=0: winlen=0, mod 0x1234 -> meanspd=gust=lull=0x1234 each sample; nwindows increments per sample.
- Clamp and full range: winlen=15, 1024 samples of 0xFFFF -> meanspd=0xFFFF, no overflow, single statvalid after sample 1024.
- Clear mid-window: winlen=2, two samples, clear with 3rd newdata, then 4 samples of 0x0200 -> meanspd=0x0200, nwindows=1.
- Enable drop: partial window then enable=0 -> outputs unchanged, no statvalid; re-enable restarts the count from 0.
- Reset mid-window (reset_n low asynchronously between clock edges) -> all outputs 0 immediately; gustangle captures the angle of the max sample only when the macro is defined.
